hms_clock: RTL
==============

HMS_CLOCK -- requirements
Module: hms_clock

Interface
REQ-001 SHALL provide parameter RESET_HH, default 8'h12, meaning BCD hour loaded on reset (legal values 8'h01..8'h12).
REQ-002 SHALL provide parameter RESET_PM, default 1'b0, meaning pm value loaded on reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port ena, input, 1, one-second tick; each cycle it is high, the time advances by one second.
REQ-006 SHALL have port load, input, 1, one-cycle request to set the time from the load_* inputs.
REQ-007 SHALL have ports load_hh, load_mm and load_ss, input, 8 each, packed-BCD time to load (tens in [7:4], units in [3:0]).
REQ-008 SHALL have port load_pm, input, 1, AM/PM value to load.
REQ-009 SHALL have ports hh, mm and ss, output, 8 each, registered packed-BCD time.
REQ-010 SHALL have port pm, output, 1, registered flag: 0 = AM, 1 = PM.
REQ-011 SHALL have port min_tick, output, 1, registered one-cycle pulse on ss wrap 59->00.
REQ-012 SHALL have port hour_tick, output, 1, registered one-cycle pulse on mm wrap 59->00 caused by a tick.
REQ-013 SHALL have port load_err, output, 1, registered one-cycle pulse when a load request is rejected.

Function
REQ-014 SHALL keep all outputs registered, updating on the rising clk edge after the qualifying input cycle (latency 1).
REQ-015 SHALL resolve inputs by priority: reset > load > ena.
REQ-016 SHALL, on ena with no load: increment ss units; at units 9, wrap units to 0 and increment tens; at ss=59, set ss=00 and advance mm.
REQ-017 SHALL advance mm under the same BCD rules as ss; at mm=59 with the carry in, set mm=00 and advance hh.
REQ-018 SHALL advance hh 01..12: 09->10; 11->12 with pm toggled; 12->01 with pm unchanged.
REQ-019 SHALL make 11:59:59 AM + tick -> 12:00:00 PM, and 11:59:59 PM + tick -> 12:00:00 AM.
REQ-020 SHALL pulse min_tick in the same cycle the ss=00 result appears, and pulse hour_tick in the same cycle the mm=00 result appears; both are otherwise 0.
REQ-021 SHALL advance exactly one second per ena cycle when ena is held high for consecutive cycles, with no skipped or missed carries.
REQ-022 SHALL validate a load: every units digit <=9; ss and mm tens <=5; hh in 01..12 BCD.
REQ-023 SHALL, on a valid load, set hh/mm/ss/pm from load_*, drop any simultaneous ena tick, and not pulse min_tick or hour_tick.
REQ-024 SHALL, on an invalid load, leave all time state unchanged, drop any simultaneous ena tick, and pulse load_err for one cycle.
REQ-025 SHALL hold the time constant, with all pulse outputs 0, in cycles with ena=0 and load=0.
REQ-026 SHALL produce only legal BCD time values on every output, given legal parameters.

Reset
REQ-027 SHALL, on a clk edge with reset=1, set hh=RESET_HH, mm=8'h00, ss=8'h00, pm=RESET_PM, and min_tick=hour_tick=load_err=0.
REQ-028 SHALL let reset override a simultaneous load or ena, including mid-carry (e.g. at 11:59:59), and leave no pending carry or pulse afterwards.
REQ-029 SHALL not require a clock-free state at power-up; behaviour before the first reset is undefined.

Verification
REQ-030 SHALL have the bench cover: reset, then 60 ena pulses -> ss 00..59 then ss=00, mm=01, min_tick high exactly once, hour_tick low throughout.
REQ-031 SHALL have the bench cover: load 11:59:59 AM, then one ena -> 12:00:00 pm=1, with min_tick and hour_tick both pulsed.
REQ-032 SHALL have the bench cover: load 12:59:59 PM, then one ena -> 01:00:00 pm=1, with no pm toggle.
REQ-033 SHALL have the bench cover: load hh=8'h13 (also mm=8'h60 and ss=8'h0A) -> time unchanged and load_err pulsed once per attempt.
REQ-034 SHALL have the bench cover: load and ena asserted in the same cycle with valid 05:30:00 -> exactly 05:30:00 next cycle, not 05:30:01.
REQ-035 SHALL have the bench cover: ena held high continuously with reset asserted at 11:59:59 -> 12:00:00 AM and all pulses 0, then counting resumes from 12:00:01.

Source files
------------

// File: rtl/hms_clock.sv
// 12-hour BCD wall clock (hh:mm:ss + AM/PM) advanced by a one-second enable,
// with validated parallel load and registered carry pulses.
module hms_clock #(
  parameter logic [7:0] RESET_HH = 8'h12,
  parameter logic       RESET_PM = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       load_pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       load_err
);

  localparam int unsigned DIG_W = 4;
  localparam int unsigned BCD_W = 2 * DIG_W;

  // Two-digit BCD increment modulo 60; MSB of the result is the wrap carry.
  function automatic logic [BCD_W:0] inc_mod60(input logic [BCD_W-1:0] v);
    logic [BCD_W:0] r;
    if (v == 8'h59)
      r = {1'b1, 8'h00};
    else if (v[DIG_W-1:0] == 4'd9)
      r = {1'b0, DIG_W'(v[BCD_W-1:DIG_W] + 4'd1), 4'd0};
    else
      r = {1'b0, v[BCD_W-1:DIG_W], DIG_W'(v[DIG_W-1:0] + 4'd1)};
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] inc_hour(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    if (v == 8'h12)
      r = 8'h01;
    else if (v[DIG_W-1:0] == 4'd9)
      r = {DIG_W'(v[BCD_W-1:DIG_W] + 4'd1), 4'd0};
    else
      r = {v[BCD_W-1:DIG_W], DIG_W'(v[DIG_W-1:0] + 4'd1)};
    return r;
  endfunction

  function automatic logic sexa_ok(input logic [BCD_W-1:0] v);
    return (v[DIG_W-1:0] <= 4'd9) && (v[BCD_W-1:DIG_W] <= 4'd5);
  endfunction

  function automatic logic hour_ok(input logic [BCD_W-1:0] v);
    return ((v[BCD_W-1:DIG_W] == 4'd0) && (v[DIG_W-1:0] != 4'd0) && (v[DIG_W-1:0] <= 4'd9)) ||
           ((v[BCD_W-1:DIG_W] == 4'd1) && (v[DIG_W-1:0] <= 4'd2));
  endfunction

  logic [BCD_W-1:0] ss_inc;
  logic [BCD_W-1:0] mm_inc;
  logic [BCD_W-1:0] hh_inc;
  logic             ss_wrap;
  logic             mm_wrap;
  logic             pm_flip;
  logic             load_ok;

  // Next-second candidates; carries ripple combinationally so every tick is complete.
  always_comb begin
    ss_inc  = '0;
    mm_inc  = '0;
    ss_wrap = 1'b0;
    mm_wrap = 1'b0;
    {ss_wrap, ss_inc} = inc_mod60(ss);
    {mm_wrap, mm_inc} = inc_mod60(mm);
    hh_inc  = inc_hour(hh);
    pm_flip = (hh == 8'h11);
    load_ok = hour_ok(load_hh) && sexa_ok(load_mm) && sexa_ok(load_ss);
  end

  // Time and pulse registers; priority reset > load > ena.
  always_ff @(posedge clk) begin
    if (reset) begin
      hh        <= RESET_HH;
      mm        <= 8'h00;
      ss        <= 8'h00;
      pm        <= RESET_PM;
      min_tick  <= 1'b0;
      hour_tick <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      min_tick  <= 1'b0;
      hour_tick <= 1'b0;
      load_err  <= 1'b0;
      if (load) begin
        if (load_ok) begin
          hh <= load_hh;
          mm <= load_mm;
          ss <= load_ss;
          pm <= load_pm;
        end else begin
          load_err <= 1'b1;
        end
      end else if (ena) begin
        ss <= ss_inc;
        if (ss_wrap) begin
          min_tick <= 1'b1;
          mm       <= mm_inc;
          if (mm_wrap) begin
            hour_tick <= 1'b1;
            hh        <= hh_inc;
            if (pm_flip) pm <= ~pm;
          end
        end
      end
    end
  end

endmodule
